// File: rtl/nrom_cart_arbiter.sv
// rtl/nrom_cart_arbiter.sv - CPU/PPU round-robin arbiter onto one iNES cartridge image ROM
// Optional: NROM_CART_ARB_NROM256_EN selects 32 KiB unmirrored PRG (NROM-256).
module nrom_cart_arbiter #(
  parameter int HDR_BYTES = 16,
  parameter int PRG_BYTES = 16384,
  parameter int CHR_BYTES = 8192,
  parameter int ROM_AW    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [15:0]       cpu_ab,
  output logic              cpu_busy,
  output logic              cpu_ack,
  output logic [7:0]        cpu_do,
  output logic              cpu_oor,
  input  logic              ppu_req,
  input  logic [15:0]       ppu_ab,
  output logic              ppu_busy,
  output logic              ppu_ack,
  output logic [7:0]        ppu_do,
  output logic              ppu_oor,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_q,
  output logic              drop_err
);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t            state;
  logic              cpu_pend, ppu_pend;
  logic              last_grant;  // 1 = PPU was served last
  logic              win;         // 1 = PPU owns the current transaction
  logic [15:0]       cpu_addr;
  logic [13:0]       ppu_addr;
  logic [ROM_AW-1:0] cpu_off, ppu_off;
  logic              pick, sel_oor, any_pend;
  logic              cpu_take, ppu_take, cpu_drop, ppu_drop;
  logic              unused_ppu_hi;

  // PPU space is 14 bits; the upper address lines only mirror.
  assign unused_ppu_hi = ^ppu_ab[15:14];

`ifdef NROM_CART_ARB_NROM256_EN
  localparam int CHR_BASE = HDR_BYTES + 32768;
  assign cpu_off = ROM_AW'(HDR_BYTES) + ROM_AW'(cpu_addr[14:0]);
`else
  localparam int CHR_BASE = HDR_BYTES + PRG_BYTES;
  assign cpu_off = ROM_AW'(HDR_BYTES) + ROM_AW'(cpu_addr & 16'(PRG_BYTES - 1));
`endif
  assign ppu_off = ROM_AW'(CHR_BASE) + ROM_AW'(ppu_addr & 14'(CHR_BYTES - 1));

  assign cpu_busy = cpu_pend;
  assign ppu_busy = ppu_pend;
  assign any_pend = cpu_pend | ppu_pend;

  // Ties go to whichever side was not served last.
  assign pick     = ppu_pend && (!cpu_pend || !last_grant);
  assign sel_oor  = pick ? ppu_addr[13] : !cpu_addr[15];
  assign rom_en   = (state == IDLE) && any_pend && !sel_oor;
  assign rom_addr = pick ? ppu_off : cpu_off;

  // The winner may re-strobe during its own ack cycle, since its flag clears that same edge.
  assign cpu_take = cpu_req && (!cpu_pend || (state == RESP && !win));
  assign ppu_take = ppu_req && (!ppu_pend || (state == RESP && win));
  assign cpu_drop = cpu_req && !cpu_take;
  assign ppu_drop = ppu_req && !ppu_take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cpu_pend   <= 1'b0;
      ppu_pend   <= 1'b0;
      last_grant <= 1'b1;
      win        <= 1'b0;
      cpu_addr   <= '0;
      ppu_addr   <= '0;
      cpu_ack    <= 1'b0;
      cpu_do     <= '0;
      cpu_oor    <= 1'b0;
      ppu_ack    <= 1'b0;
      ppu_do     <= '0;
      ppu_oor    <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      ppu_ack <= 1'b0;
      if (cpu_drop || ppu_drop) drop_err <= 1'b1;

      case (state)
        IDLE: begin
          if (any_pend) begin
            win <= pick;
            if (sel_oor) begin
              state <= RESP;
              if (pick) begin
                ppu_ack <= 1'b1;
                ppu_oor <= 1'b1;
              end else begin
                cpu_ack <= 1'b1;
                cpu_oor <= 1'b1;
              end
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          state <= RESP;
          if (win) begin
            ppu_ack <= 1'b1;
            ppu_do  <= rom_q;
            ppu_oor <= 1'b0;
          end else begin
            cpu_ack <= 1'b1;
            cpu_do  <= rom_q;
            cpu_oor <= 1'b0;
          end
        end
        RESP: begin
          state      <= IDLE;
          last_grant <= win;
          if (win) ppu_pend <= 1'b0;
          else     cpu_pend <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (cpu_take) begin
        cpu_pend <= 1'b1;
        cpu_addr <= cpu_ab;
      end
      if (ppu_take) begin
        ppu_pend <= 1'b1;
        ppu_addr <= ppu_ab[13:0];
      end
    end
  end

endmodule

// File: tb/tb_nrom_cart_arbiter.sv
// tb/tb_nrom_cart_arbiter.sv - scoreboard bench for nrom_cart_arbiter
module tb_nrom_cart_arbiter;

`ifdef NROM_CART_ARB_NROM256_EN
  localparam int AW = 16;
  localparam logic [15:0] OFF_C005 = 16'h4015;
  localparam logic [15:0] OFF_P003 = 16'h8013;
  localparam logic [15:0] OFF_C100 = 16'h4110;
  localparam logic [15:0] OFF_FFFF = 16'h800F;
  localparam logic [15:0] OFF_P100 = 16'h8110;
  localparam logic [15:0] OFF_P1FF = 16'hA00F;
`else
  localparam int AW = 15;
  localparam logic [15:0] OFF_C005 = 16'h0015;
  localparam logic [15:0] OFF_P003 = 16'h4013;
  localparam logic [15:0] OFF_C100 = 16'h0110;
  localparam logic [15:0] OFF_FFFF = 16'h400F;
  localparam logic [15:0] OFF_P100 = 16'h4110;
  localparam logic [15:0] OFF_P1FF = 16'h600F;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req = 1'b0, ppu_req = 1'b0;
  logic [15:0]   cpu_ab = '0, ppu_ab = '0;
  logic          cpu_busy, cpu_ack, cpu_oor, ppu_busy, ppu_ack, ppu_oor;
  logic [7:0]    cpu_do, ppu_do, rom_q;
  logic          rom_en, drop_err;
  logic [AW-1:0] rom_addr;
  logic [15:0]   ra;

  typedef struct { logic [15:0] addr; int cyc; } rom_e_t;
  typedef struct { logic [7:0] d; logic oor; int cyc; } rsp_t;

  rom_e_t romq[$];
  rsp_t   cpuq[$];
  rsp_t   ppuq[$];
  rom_e_t re;
  rsp_t   rs;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  int t0;
  logic [7:0] last_cpu = '0, last_ppu = '0;

  nrom_cart_arbiter #(.HDR_BYTES(16), .PRG_BYTES(16384), .CHR_BYTES(8192), .ROM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_ab(cpu_ab), .cpu_busy(cpu_busy), .cpu_ack(cpu_ack),
    .cpu_do(cpu_do), .cpu_oor(cpu_oor),
    .ppu_req(ppu_req), .ppu_ab(ppu_ab), .ppu_busy(ppu_busy), .ppu_ack(ppu_ack),
    .ppu_do(ppu_do), .ppu_oor(ppu_oor),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_q(rom_q), .drop_err(drop_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] img(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign ra = 16'(rom_addr);
  always @(posedge clk) if (rom_en) rom_q <= img(ra);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rom_en) begin
        if (romq.size() == 0) chk("rom_en_unexpected", 32'(rom_en), 0);
        else begin
          re = romq.pop_front();
          chk("rom_addr", 32'(ra), 32'(re.addr));
          chk("rom_cycle", cyc, re.cyc);
        end
      end
      if (cpu_ack) begin
        if (cpu_ack && cpuq.size() == 0) chk("cpu_ack_unexpected", 32'(cpu_ack), 0);
        else begin
          rs = cpuq.pop_front();
          chk("cpu_do", 32'(cpu_do), 32'(rs.d));
          chk("cpu_oor", 32'(cpu_oor), 32'(rs.oor));
          chk("cpu_ack_cycle", cyc, rs.cyc);
        end
      end
      if (ppu_ack) begin
        if (ppuq.size() == 0) chk("ppu_ack_unexpected", 32'(ppu_ack), 0);
        else begin
          rs = ppuq.pop_front();
          chk("ppu_do", 32'(ppu_do), 32'(rs.d));
          chk("ppu_oor", 32'(ppu_oor), 32'(rs.oor));
          chk("ppu_ack_cycle", cyc, rs.cyc);
        end
      end
    end
  end

  task automatic cpu_rd(input logic [15:0] a, input logic [15:0] off, input logic oor);
    @(negedge clk);
    t0 = cyc;
    cpu_req = 1'b1;
    cpu_ab  = a;
    if (oor) cpuq.push_back('{last_cpu, 1'b1, t0 + 2});
    else begin
      romq.push_back('{off, t0 + 1});
      last_cpu = img(off);
      cpuq.push_back('{last_cpu, 1'b0, t0 + 3});
    end
    @(negedge clk);
    cpu_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic ppu_rd(input logic [15:0] a, input logic [15:0] off, input logic oor);
    @(negedge clk);
    t0 = cyc;
    ppu_req = 1'b1;
    ppu_ab  = a;
    if (oor) ppuq.push_back('{last_ppu, 1'b1, t0 + 2});
    else begin
      romq.push_back('{off, t0 + 1});
      last_ppu = img(off);
      ppuq.push_back('{last_ppu, 1'b0, t0 + 3});
    end
    @(negedge clk);
    ppu_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_cpu = '0;
    last_ppu = '0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rom_en", 32'(rom_en), 0);
    chk("rst_busy", 32'({cpu_busy, ppu_busy}), 0);
    chk("rst_acks", 32'({cpu_ack, ppu_ack, cpu_oor, ppu_oor}), 0);
    chk("rst_do", 32'({cpu_do, ppu_do}), 0);
    chk("rst_drop_err", 32'(drop_err), 0);
    rst = 1'b0;

    // Basic CPU read, busy rises the cycle after the strobe
    @(negedge clk);
    t0 = cyc;
    cpu_req = 1'b1;
    cpu_ab  = 16'hC000;
    romq.push_back('{16'h0010, t0 + 1});
    last_cpu = img(16'h0010);
    cpuq.push_back('{last_cpu, 1'b0, t0 + 3});
    @(negedge clk);
    cpu_req = 1'b0;
    chk("cpu_busy_rise", 32'(cpu_busy), 1);
    repeat (3) @(negedge clk);
    chk("cpu_busy_fall", 32'(cpu_busy), 0);

    // PRG mirroring
    cpu_rd(16'h8005, 16'h0015, 1'b0);
    cpu_rd(16'hC005, OFF_C005, 1'b0);

    // CHR read, then out-of-range for both sides
    ppu_rd(16'h0003, OFF_P003, 1'b0);
    ppu_rd(16'h2000, 16'h0000, 1'b1);
    cpu_rd(16'h1234, 16'h0000, 1'b1);

    // Strobe while busy is dropped, original address still served
    @(negedge clk);
    t0 = cyc;
    cpu_req = 1'b1;
    cpu_ab  = 16'hC001;
    romq.push_back('{16'h0011, t0 + 1});
    last_cpu = img(16'h0011);
    cpuq.push_back('{last_cpu, 1'b0, t0 + 3});
    @(negedge clk);
    cpu_ab = 16'hC002;
    @(negedge clk);
    cpu_req = 1'b0;
    chk("drop_err_set", 32'(drop_err), 1);
    repeat (4) @(negedge clk);
    ppu_rd(16'h0003, OFF_P003, 1'b0);
    chk("drop_err_sticky", 32'(drop_err), 1);

    // Simultaneous strobes from reset, then saturated alternation via ack-cycle re-strobes
    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 0) begin
        t0 = cyc;
        romq.push_back('{OFF_C100, t0 + 1});
        romq.push_back('{OFF_P100, t0 + 4});
        romq.push_back('{OFF_FFFF, t0 + 7});
        romq.push_back('{OFF_P1FF, t0 + 10});
        cpuq.push_back('{img(OFF_C100), 1'b0, t0 + 3});
        ppuq.push_back('{img(OFF_P100), 1'b0, t0 + 6});
        cpuq.push_back('{img(OFF_FFFF), 1'b0, t0 + 9});
        ppuq.push_back('{img(OFF_P1FF), 1'b0, t0 + 12});
      end
      cpu_req = (i == 0 || i == 3);
      cpu_ab  = (i == 3) ? 16'hFFFF : 16'hC100;
      ppu_req = (i == 0 || i == 6);
      ppu_ab  = (i == 6) ? 16'h1FFF : 16'h0100;
    end
    cpu_req = 1'b0;
    ppu_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_drop_on_ack_restrobe", 32'(drop_err), 0);
    last_cpu = img(OFF_FFFF);
    last_ppu = img(OFF_P1FF);

    // Reset while in READ aborts the transaction without an ack
    @(negedge clk);
    t0 = cyc;
    cpu_req = 1'b1;
    cpu_ab  = 16'hC003;
    romq.push_back('{16'h0013, t0 + 1});
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_rom_en", 32'(rom_en), 0);
    chk("abort_busy", 32'({cpu_busy, ppu_busy}), 0);
    chk("abort_outputs", 32'({cpu_ack, ppu_ack, cpu_do, ppu_do}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_cpu = '0;
    last_ppu = '0;
    cpu_rd(16'hC000, 16'h0010, 1'b0);

    repeat (4) @(negedge clk);
    chk("rom_queue_empty", 32'(romq.size()), 0);
    chk("cpu_queue_empty", 32'(cpuq.size()), 0);
    chk("ppu_queue_empty", 32'(ppuq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
